// File: rtl/alu_decode_stage.sv
// rtl/alu_decode_stage.sv - RV64 ALU decode stage: legality check, field split, output FIFO, drop counters
module alu_decode_stage #(
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_inst,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [9:0]       out_opcode,
  output logic [4:0]       out_regA,
  output logic [11:0]      out_regB,
  output logic [4:0]       out_regDest,
  output logic             illegal,
  output logic [31:0]      illegal_inst,
  output logic [CNT_W-1:0] illegal_cnt,
  output logic [CNT_W-1:0] nop_cnt
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W:0]   OCC_ONE  = (PTR_W+1)'(1);
  localparam logic [PTR_W:0]   OCC_FULL = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic [6:0] op;
  logic [2:0] f3;
  logic [6:0] f7;
  logic [5:0] hi6;
  logic       legal;

  assign op  = in_inst[6:0];
  assign f3  = in_inst[14:12];
  assign f7  = in_inst[31:25];
  assign hi6 = in_inst[31:26];

  always_comb begin
    legal = 1'b0;
    case (op)
      7'h13: begin
        case (f3)
          3'd1:    legal = (hi6 == 6'h00);
          3'd5:    legal = (hi6 == 6'h00) || (hi6 == 6'h10);
          default: legal = 1'b1;
        endcase
      end
      7'h1b: begin
        case (f3)
          3'd0:    legal = 1'b1;
          3'd1:    legal = (f7 == 7'h00);
          3'd5:    legal = (f7 == 7'h00) || (f7 == 7'h20);
          default: legal = 1'b0;
        endcase
      end
      7'h33: begin
        legal = (f7 == 7'h00) || (f7 == 7'h01) ||
                ((f7 == 7'h20) && ((f3 == 3'd0) || (f3 == 3'd5)));
      end
      7'h3b: begin
        case (f7)
          7'h00:   legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd5);
          7'h01:   legal = (f3 == 3'd0) || (f3 >= 3'd4);
          7'h20:   legal = (f3 == 3'd0) || (f3 == 3'd5);
          default: legal = 1'b0;
        endcase
      end
      default: legal = 1'b0;
    endcase
  end

  // Entry packs {opcode, regA, regB, regDest} into exactly 32 bits.
  logic [31:0]      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             ready_en;
  logic             full;
  logic             accept;
  logic             push;
  logic             pop;
  logic [31:0]      entry;
  logic [31:0]      head;

  assign full     = (count == OCC_FULL);
  assign in_ready = ready_en && !full && !flush;
  assign accept   = in_valid && in_ready;
  assign push     = accept && legal && (in_inst[11:7] != 5'd0);
  assign out_valid = (count != '0);
  assign pop      = out_valid && out_ready && !flush;
  assign entry    = {in_inst[14:12], in_inst[6:0], in_inst[19:15], in_inst[31:20], in_inst[11:7]};
  assign head     = mem[rd_ptr];

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) ready_en <= 1'b0;
    else        ready_en <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= entry;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + OCC_ONE;
        2'b01:   count <= count - OCC_ONE;
        default: count <= count;
      endcase
    end
  end

  always_comb begin
    out_opcode  = '0;
    out_regA    = '0;
    out_regB    = '0;
    out_regDest = '0;
    if (out_valid) begin
      out_opcode  = head[31:22];
      out_regA    = head[21:17];
      out_regB    = head[16:5];
      out_regDest = head[4:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      illegal      <= 1'b0;
      illegal_inst <= '0;
      illegal_cnt  <= '0;
      nop_cnt      <= '0;
    end else begin
      illegal <= accept && !legal;
      if (accept && !legal) begin
        illegal_inst <= in_inst;
        if (illegal_cnt != CNT_MAX) illegal_cnt <= illegal_cnt + CNT_ONE;
      end else if (accept && (in_inst[11:7] == 5'd0)) begin
        if (nop_cnt != CNT_MAX) nop_cnt <= nop_cnt + CNT_ONE;
      end
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// tb/tb_alu_decode_stage.sv - randomized scoreboard bench for alu_decode_stage
module tb_alu_decode_stage;

  localparam int DEPTH = 2;
  localparam int CNT_W = 4;
  localparam int CMAX  = 15;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic             flush = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      in_inst = '0;
  logic             in_ready;
  logic             out_valid;
  logic [9:0]       out_opcode;
  logic [4:0]       out_regA;
  logic [11:0]      out_regB;
  logic [4:0]       out_regDest;
  logic             illegal;
  logic [31:0]      illegal_inst;
  logic [CNT_W-1:0] illegal_cnt;
  logic [CNT_W-1:0] nop_cnt;

  alu_decode_stage #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_regA(out_regA), .out_regB(out_regB), .out_regDest(out_regDest),
    .illegal(illegal), .illegal_inst(illegal_inst),
    .illegal_cnt(illegal_cnt), .nop_cnt(nop_cnt)
  );

  always #5 clk = ~clk;

  int          passed = 0;
  int          total = 0;
  int          m_ill = 0;
  int          m_nop = 0;
  int          pops = 0;
  logic [31:0] m_last = '0;
  logic [31:0] sbq[$];
  logic [31:0] mon_exp;
  bit          rdone;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  // Legality written from the supported instruction list, not from a decoder structure.
  function automatic bit model_legal(input logic [31:0] i);
    int op, f3, f7, hi6;
    op = int'(i[6:0]); f3 = int'(i[14:12]); f7 = int'(i[31:25]); hi6 = int'(i[31:26]);
    if (op == 'h13) return !(f3 == 1 && hi6 != 0) && !(f3 == 5 && hi6 != 0 && hi6 != 'h10);
    if (op == 'h1b) return (f3 == 0) || (f3 == 1 && f7 == 0) || (f3 == 5 && (f7 == 0 || f7 == 'h20));
    if (op == 'h33) return (f7 == 0) || (f7 == 1) || (f7 == 'h20 && (f3 == 0 || f3 == 5));
    if (op == 'h3b) return (f7 == 0 && (f3 == 0 || f3 == 1 || f3 == 5)) ||
                           (f7 == 1 && f3 != 1 && f3 != 2 && f3 != 3) ||
                           (f7 == 'h20 && (f3 == 0 || f3 == 5));
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_fields(input logic [31:0] i);
    return {i[14:12], i[6:0], i[19:15], i[31:20], i[11:7]};
  endfunction

  function automatic logic [31:0] rand_inst();
    logic [31:0] i;
    logic [6:0]  f7s [5];
    logic [6:0]  ops [6];
    f7s[0] = 7'h00; f7s[1] = 7'h01; f7s[2] = 7'h20; f7s[3] = 7'h21; f7s[4] = 7'($urandom);
    ops[0] = 7'h13; ops[1] = 7'h1b; ops[2] = 7'h33; ops[3] = 7'h3b; ops[4] = 7'($urandom); ops[5] = 7'h13;
    i = $urandom;
    i[6:0]   = ops[$urandom_range(0, 5)];
    i[31:25] = f7s[$urandom_range(0, 4)];
    if ($urandom_range(0, 7) == 0) i[11:7] = 5'd0;
    return i;
  endfunction

  task automatic send(input logic [31:0] inst);
    int waited;
    bit exp_ill;
    waited = 0;
    in_valid = 1'b1;
    in_inst  = inst;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!in_ready) begin
      check("accept_timeout", 64'(in_ready), 64'(1));
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    exp_ill = !model_legal(inst);
    if (exp_ill) begin
      m_ill++;
      m_last = inst;
    end else if (inst[11:7] == 5'd0) m_nop++;
    else sbq.push_back(exp_fields(inst));
    #1;
    in_valid = 1'b0;
    check("illegal_pulse", 64'(illegal), 64'(exp_ill));
    if (exp_ill) check("illegal_inst", 64'(illegal_inst), 64'(inst));
  endtask

  task automatic drain();
    int w;
    w = 0;
    while (sbq.size() > 0 && w < 100) begin
      @(posedge clk);
      w++;
    end
    #1;
    check("drain_left", 64'(sbq.size()), 64'(0));
  endtask

  task automatic check_cnts(input string tag);
    check({tag, "_illegal_cnt"}, 64'(illegal_cnt), 64'(sat(m_ill)));
    check({tag, "_nop_cnt"}, 64'(nop_cnt), 64'(sat(m_nop)));
    check({tag, "_illegal_inst"}, 64'(illegal_inst), 64'(m_last));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_illegal"}, 64'(illegal), 64'(0));
    check({tag, "_fields"}, 64'({out_opcode, out_regA, out_regB, out_regDest}), 64'(0));
    check({tag, "_illegal_inst"}, 64'(illegal_inst), 64'(0));
    check({tag, "_illegal_cnt"}, 64'(illegal_cnt), 64'(0));
    check({tag, "_nop_cnt"}, 64'(nop_cnt), 64'(0));
  endtask

  // Monitor: every pop the DUT takes must match the scoreboard head.
  always @(negedge clk) begin
    if (reset && !flush && out_valid && out_ready) begin
      if (sbq.size() == 0) check("unexpected_out", 64'(1), 64'(0));
      else begin
        mon_exp = sbq.pop_front();
        check("out_fields", 64'({out_opcode, out_regA, out_regB, out_regDest}), 64'(mon_exp));
        pops++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int p0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_state("reset");
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("in_ready_before_edge", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    check("in_ready_after_edge", 64'(in_ready), 64'(1));

    out_ready = 1'b1;
    send(32'h00510093);
    check("addi_valid", 64'(out_valid), 64'(1));
    check("addi_fields", 64'({out_opcode, out_regA, out_regB, out_regDest}),
          64'({10'h013, 5'd2, 12'h005, 5'd1}));
    send(32'h405201B3);
    check("sub_fields", 64'({out_opcode, out_regA, out_regB, out_regDest}),
          64'({10'h033, 5'd4, 12'h405, 5'd3}));
    send(32'h40522133);
    send(32'h0000A083);
    @(posedge clk);
    #1;
    check("illegal_one_cycle", 64'(illegal), 64'(0));
    check("lw_no_output", 64'(out_valid), 64'(0));
    check("idle_fields_zero", 64'({out_opcode, out_regA, out_regB, out_regDest}), 64'(0));
    send(32'h00000013);
    send(32'h02009093);
    send(32'h04009093);
    drain();
    check("directed_illegal_cnt", 64'(illegal_cnt), 64'(3));
    check("directed_nop_cnt", 64'(nop_cnt), 64'(1));
    check_cnts("directed");

    out_ready = 1'b0;
    p0 = pops;
    send(32'h00108113);
    send(32'h002181B3);
    check("full_in_ready", 64'(in_ready), 64'(0));
    in_valid = 1'b1;
    in_inst  = 32'h02320233;
    repeat (2) begin
      @(negedge clk);
      check("full_held", 64'(in_ready), 64'(0));
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h02320233);
    drain();
    check("full_pops", 64'(pops - p0), 64'(3));

    rdone = 1'b0;
    fork
      begin
        for (int k = 0; k < 300; k++) send(rand_inst());
        rdone = 1'b1;
      end
      begin
        while (!rdone) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();
    check_cnts("random");

    out_ready = 1'b0;
    send(32'h00510093);
    send(32'h00628293);
    check("pre_flush_valid", 64'(out_valid), 64'(1));
    flush = 1'b1;
    #1;
    check("flush_in_ready", 64'(in_ready), 64'(0));
    @(posedge clk);
    #1;
    flush = 1'b0;
    sbq.delete();
    check("flush_out_valid", 64'(out_valid), 64'(0));
    check_cnts("flush");
    @(posedge clk);
    #1;
    check("post_flush_in_ready", 64'(in_ready), 64'(1));

    send(32'h00730313);
    send(32'h0000A083);
    send(32'h00838393);
    #2;
    reset = 1'b0;
    #1;
    sbq.delete();
    m_ill = 0; m_nop = 0; m_last = '0;
    check_reset_state("midreset");
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    p0 = pops;
    send(32'h405201BB);
    drain();
    check("after_reset_pops", 64'(pops - p0), 64'(1));
    check_cnts("final");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
